// File: rtl/uplink_arbiter.sv
// Round-robin uplink arbiter: shares one group-router injection port among NUM_REQ leaf NIs,
// with bounded burst locking. Define ARB_STATS_EN to enable per-requester grant counters.
module uplink_arbiter #(
    parameter int DATA_W    = 16,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_in,
    input  logic [NUM_REQ-1:0]          req_valid_in,
    input  logic [NUM_REQ-1:0]          req_lock_in,
    output logic [NUM_REQ-1:0]          req_ready_out,
    output logic [DATA_W-1:0]           up_data_out,
    output logic                        up_valid_out,
    input  logic                        up_ready_in,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id_out,
    output logic                        locked_out,
    output logic [NUM_REQ*16-1:0]       grant_count_out
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST) + 1;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [BCW-1:0]     burst_q, burst_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [DATA_W-1:0]  up_data_q;
    logic               up_valid_q;
    logic [IDW-1:0]     up_id_q;

    logic               can_load, hold, found, xfer;
    logic [IDW-1:0]     base, win, idx;
    logic [NUM_REQ-1:0] eligible;
    logic [BCW-1:0]     burst_inc;

    // A LOCKED owner that has dropped its lock falls back to IDLE rules this same cycle,
    // searching from owner+1.
    always_comb begin
        can_load  = !up_valid_q || up_ready_in;
        hold      = (state_q == S_LOCKED) && req_lock_in[owner_q];
        base      = (state_q == S_LOCKED) ? IDW'(owner_q + 1'b1) : rr_q;
        eligible  = hold ? (req_valid_in & (NUM_REQ'(1) << owner_q)) : req_valid_in;
        found     = 1'b0;
        win       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'(32'(base) + k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        xfer          = found && can_load && reset;
        req_ready_out = xfer ? (NUM_REQ'(1) << win) : '0;
        burst_inc     = burst_q + 1'b1;

        state_d = state_q;
        owner_d = owner_q;
        burst_d = burst_q;
        rr_d    = rr_q;
        if (hold) begin
            if (xfer) begin
                if (burst_inc == BCW'(MAX_BURST)) begin
                    state_d = S_IDLE;
                    burst_d = '0;
                    rr_d    = IDW'(owner_q + 1'b1);
                end else begin
                    burst_d = burst_inc;
                end
            end
        end else begin
            state_d = S_IDLE;
            burst_d = '0;
            rr_d    = base;
            if (xfer) begin
                if (req_lock_in[win] && (MAX_BURST > 1)) begin
                    state_d = S_LOCKED;
                    owner_d = win;
                    burst_d = BCW'(1);
                end else begin
                    rr_d = IDW'(win + 1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            burst_q    <= '0;
            rr_q       <= '0;
            up_data_q  <= '0;
            up_valid_q <= 1'b0;
            up_id_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            rr_q    <= rr_d;
            if (xfer) begin
                up_data_q  <= req_data_in[win*DATA_W +: DATA_W];
                up_valid_q <= 1'b1;
                up_id_q    <= win;
            end else if (up_ready_in) begin
                up_valid_q <= 1'b0;
            end
        end
    end

    assign up_data_out  = up_data_q;
    assign up_valid_out = up_valid_q;
    assign grant_id_out = up_id_q;
    assign locked_out   = (state_q == S_LOCKED);

`ifdef ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!reset)
                cnt_q[i] <= '0;
            else if (xfer && win == IDW'(i) && cnt_q[i] != 16'hFFFF)
                cnt_q[i] <= cnt_q[i] + 16'd1;
        end
    end

    assign grant_count_out = cnt_q;
`else
    assign grant_count_out = '0;
`endif

endmodule

// File: tb/tb_uplink_arbiter.sv
// Self-checking bench for uplink_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural scheduling model.
module tb_uplink_arbiter;
    localparam int N    = 4;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   data;
    logic [3:0]    valid, lock, ready;
    logic          up_ready;
    logic [15:0]   up_data;
    logic          up_valid;
    logic [1:0]    gid;
    logic          locked;
    logic [63:0]   gcount;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    bit          m_lk;
    int          m_own, m_bc, m_ptr, m_id;
    bit          m_uv;
    logic [15:0] m_ud;
    int          m_gc[N];

    always #5 clk = ~clk;

    uplink_arbiter dut (
        .clk(clk), .reset(rst_n), .req_data_in(data), .req_valid_in(valid),
        .req_lock_in(lock), .req_ready_out(ready), .up_data_out(up_data),
        .up_valid_out(up_valid), .up_ready_in(up_ready), .grant_id_out(gid),
        .locked_out(locked), .grant_count_out(gcount)
    );

    function automatic int m_winner();
        int start;
        if (m_lk && lock[m_own]) return valid[m_own] ? m_own : -1;
        start = m_lk ? (m_own + 1) % N : m_ptr;
        for (int k = 0; k < N; k++)
            if (valid[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int w;
        w = m_winner();
        if (!rst_n || w < 0 || !(!m_uv || up_ready)) return 4'b0;
        return 4'(1 << w);
    endfunction

    function automatic logic [63:0] m_gcount();
        logic [63:0] v;
        v = '0;
`ifdef ARB_STATS_EN
        for (int i = 0; i < N; i++) v[i*16 +: 16] = 16'(m_gc[i]);
`endif
        return v;
    endfunction

    // advance one clock edge in both DUT and model; returns at posedge+1
    task automatic tick();
        int w, start;
        logic [3:0] r;
        bit lm;
        w     = m_winner();
        r     = m_ready();
        lm    = m_lk && lock[m_own];
        start = m_lk ? (m_own + 1) % N : m_ptr;
        @(posedge clk);
        if (!rst_n) begin
            m_lk = 0; m_own = 0; m_bc = 0; m_ptr = 0; m_uv = 0; m_ud = '0; m_id = 0;
            for (int i = 0; i < N; i++) m_gc[i] = 0;
        end else begin
            if (r != 0) begin
                m_uv = 1; m_ud = data[w*16 +: 16]; m_id = w;
                if (m_gc[w] < 65535) m_gc[w]++;
            end else if (up_ready) begin
                m_uv = 0;
            end
            if (lm) begin
                if (r != 0) begin
                    m_bc++;
                    if (m_bc == MAXB) begin m_lk = 0; m_bc = 0; m_ptr = (m_own + 1) % N; end
                end
            end else begin
                m_ptr = start; m_lk = 0; m_bc = 0;
                if (r != 0) begin
                    if (lock[w] && MAXB > 1) begin m_lk = 1; m_own = w; m_bc = 1; end
                    else m_ptr = (w + 1) % N;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; valid = '0; lock = '0; up_ready = 1'b1;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; valid = 4'hF; lock = '0; up_ready = 1'b1; data = {$urandom, $urandom};
        #1;
        n_cmp++;
        if (ready !== 4'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0000", ready); end
        tick(); tick();
        n_cmp++;
        if ({up_valid, up_data, gid, locked} !== 20'h0) begin
            n_err++; $display("FAIL reset_outputs got v=%b d=%h id=%0d l=%b exp all 0", up_valid, up_data, gid, locked);
        end
        n_cmp++;
        if (gcount !== 64'h0) begin n_err++; $display("FAIL reset_counts got %h exp 0", gcount); end
        rst_n = 1;
        #1;
        n_cmp++;
        if (ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_ready got %b exp 0001", ready); end
        tick();
        n_cmp++;
        if (up_valid !== 1'b1 || gid !== 2'd0 || up_data !== data[15:0]) begin
            n_err++; $display("FAIL reset_first_grant got v=%b id=%0d d=%h exp v=1 id=0 d=%h", up_valid, gid, up_data, data[15:0]);
        end
    endtask

    task automatic test_fairness();
        logic [15:0] exp_d;
        do_reset();
        valid = 4'hF; lock = '0; up_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data = {$urandom, $urandom};
            exp_d = data[(k % 4)*16 +: 16];
            #1;
            n_cmp++;
            if (ready !== 4'(1 << (k % 4))) begin
                n_err++; $display("FAIL fair_ready[%0d] got %b exp %b", k, ready, 4'(1 << (k % 4)));
            end
            tick();
            n_cmp++;
            if (gid !== 2'(k % 4) || up_data !== exp_d || up_valid !== 1'b1) begin
                n_err++; $display("FAIL fair_grant[%0d] got id=%0d d=%h exp id=%0d d=%h", k, gid, up_data, k % 4, exp_d);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        data = {$urandom, $urandom}; data[31:16] = 16'h8C05;
        valid = 4'b0010; lock = '0; up_ready = 1'b1;
        tick();
        valid = 4'hF; up_ready = 1'b0; data[47:32] = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (ready !== 4'b0) begin n_err++; $display("FAIL bp_ready[%0d] got %b exp 0000", k, ready); end
            tick();
            n_cmp++;
            if (up_data !== 16'h8C05 || up_valid !== 1'b1 || gid !== 2'd1) begin
                n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d exp v=1 d=8c05 id=1", k, up_valid, up_data, gid);
            end
        end
        up_ready = 1'b1;
        #1;
        n_cmp++;
        if (ready !== 4'b0100) begin n_err++; $display("FAIL bp_release_ready got %b exp 0100", ready); end
        tick();
        n_cmp++;
        if (up_data !== 16'h1234 || up_valid !== 1'b1 || gid !== 2'd2) begin
            n_err++; $display("FAIL bp_next got v=%b d=%h id=%0d exp v=1 d=1234 id=2", up_valid, up_data, gid);
        end
    endtask

    task automatic test_burst();
        do_reset();
        data = {$urandom, $urandom}; valid = 4'hF; lock = '0; up_ready = 1'b1;
        tick(); tick();
        lock = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (ready !== 4'b0100) begin n_err++; $display("FAIL burst_ready[%0d] got %b exp 0100", k, ready); end
            tick();
            n_cmp++;
            if (gid !== 2'd2 || locked !== (k < 3)) begin
                n_err++; $display("FAIL burst_grant[%0d] got id=%0d lk=%b exp id=2 lk=%b", k, gid, locked, k < 3);
            end
        end
        lock = '0;
        tick();
        n_cmp++;
        if (gid !== 2'd3 || locked !== 1'b0) begin
            n_err++; $display("FAIL burst_after got id=%0d lk=%b exp id=3 lk=0", gid, locked);
        end
    endtask

    task automatic test_early_unlock();
        do_reset();
        data = {$urandom, $urandom}; valid = 4'b0001; lock = '0; up_ready = 1'b1;
        tick();
        valid = 4'hF; lock = 4'b0010;
        tick();
        n_cmp++;
        if (gid !== 2'd1 || locked !== 1'b1) begin
            n_err++; $display("FAIL unlock_lockstart got id=%0d lk=%b exp id=1 lk=1", gid, locked);
        end
        valid = 4'b1101;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++;
            if (ready !== 4'b0) begin n_err++; $display("FAIL stall_ready[%0d] got %b exp 0000", k, ready); end
            tick();
            n_cmp++;
            if (up_valid !== 1'b0 || locked !== 1'b1) begin
                n_err++; $display("FAIL stall_state[%0d] got v=%b lk=%b exp v=0 lk=1", k, up_valid, locked);
            end
        end
        lock = '0;
        #1;
        n_cmp++;
        if (ready !== 4'b0100) begin n_err++; $display("FAIL unlock_ready got %b exp 0100", ready); end
        tick();
        n_cmp++;
        if (gid !== 2'd2 || up_valid !== 1'b1 || locked !== 1'b0) begin
            n_err++; $display("FAIL unlock_grant got id=%0d v=%b lk=%b exp id=2 v=1 lk=0", gid, up_valid, locked);
        end
    endtask

    task automatic test_stats();
        logic [15:0] exp_c;
        do_reset();
        data = {$urandom, $urandom}; valid = 4'b1000; lock = '0; up_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
`ifdef ARB_STATS_EN
        exp_c = 16'd10;
`else
        exp_c = 16'd0;
`endif
        n_cmp++;
        if (gcount[63:48] !== exp_c || gcount[47:0] !== 48'h0) begin
            n_err++; $display("FAIL stats got %h exp %h_000000000000", gcount, exp_c);
        end
    endtask

    task automatic test_random();
        logic [3:0] er;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            data     = {$urandom, $urandom};
            valid    = 4'($urandom);
            lock     = 4'($urandom) & 4'($urandom) | (($urandom_range(0, 3) == 0) ? 4'hF : 4'h0);
            up_ready = ($urandom_range(0, 3) != 0);
            rst_n    = ($urandom_range(0, 63) != 0);
            #1;
            er = m_ready();
            n_cmp++;
            if (ready !== er) begin n_err++; $display("FAIL rand_ready[%0d] got %b exp %b", c, ready, er); end
            tick();
            n_cmp++;
            if (up_valid !== m_uv || locked !== m_lk || (m_uv && (up_data !== m_ud || gid !== 2'(m_id)))) begin
                n_err++;
                $display("FAIL rand_out[%0d] got v=%b d=%h id=%0d lk=%b exp v=%b d=%h id=%0d lk=%b",
                         c, up_valid, up_data, gid, locked, m_uv, m_ud, m_id, m_lk);
            end
            n_cmp++;
            if (gcount !== m_gcount()) begin
                n_err++; $display("FAIL rand_counts[%0d] got %h exp %h", c, gcount, m_gcount());
            end
        end
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; valid = '0; lock = '0; up_ready = 1'b1; data = '0;
        m_lk = 0; m_own = 0; m_bc = 0; m_ptr = 0; m_uv = 0; m_ud = '0; m_id = 0;
        for (int i = 0; i < N; i++) m_gc[i] = 0;
        test_reset();
        test_fairness();
        test_backpressure();
        test_burst();
        test_early_unlock();
        test_stats();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uplink_arbiter.md
# uplink_arbiter

Round-robin arbiter that shares one group-router injection port among the leaf network interfaces of a group (default 4 leaves, matching the 2-bit leaf field of the 6-bit routing header). It accepts already-translated 16-bit flits from each NI and forwards one flit per cycle through a single registered output. It supports bounded burst locking so a requester can send consecutive flits back to back. It sits between the per-GPU NIs and the group router's local input port.

## Interface
- DATA_W, 16, flit width (header in [15:10], payload in [9:0])
- NUM_REQ, 4, number of requesting NIs (power of 2, 2..8)
- MAX_BURST, 4, maximum flits granted in one locked burst (≥1)
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- req_data_in  input  NUM_REQ*DATA_W  flit from requester i in bits [i*DATA_W +: DATA_W]
- req_valid_in  input  NUM_REQ  requester i holds a flit
- req_lock_in  input  NUM_REQ  requester i asks to keep the grant after this flit
- req_ready_out  output  NUM_REQ  one-hot or zero; requester i's flit is taken this cycle when valid & ready
- up_data_out  output  DATA_W  flit to the group router
- up_valid_out  output  1  up_data_out is valid
- up_ready_in  input  1  router accepts the flit this cycle
- grant_id_out  output  clog2(NUM_REQ)  index of the requester that sourced the current up_data_out
- locked_out  output  1  FSM is in LOCKED
- grant_count_out  output  NUM_REQ*16  per-requester grant counters (see Configuration)

## Operation
- Output register: one entry holding up_data_out, up_valid_out and grant_id_out.
  - can_load = !up_valid_out || up_ready_in.
  - A new flit loads only when can_load is high.
- Arbitration (combinational, evaluated every cycle):
  - In IDLE, eligible = req_valid_in.
  - The winner is the first eligible index found searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready_out[winner] = can_load. All other ready bits are 0.
  - If no requester is eligible or can_load is low, req_ready_out = 0.
- Transfer happens when req_valid_in[w] && req_ready_out[w]:
  - Output register loads req_data_in[w].
  - up_valid_out is set to 1.
  - grant_id_out is set to w.
- FSM states: IDLE and LOCKED. Registers: owner, burst_cnt (width clog2(MAX_BURST)+1), rr_ptr.
  - IDLE, transfer from w with req_lock_in[w]=1 and MAX_BURST>1:
    - Go to LOCKED with owner=w and burst_cnt=1.
    - rr_ptr is unchanged.
  - IDLE, transfer without lock: rr_ptr = (w+1) mod NUM_REQ.
  - LOCKED, req_lock_in[owner]=1: eligible = owner only. Other requesters get ready=0 even if valid.
  - LOCKED, transfer from owner: burst_cnt increments.
    - If the new burst_cnt == MAX_BURST or req_lock_in[owner]=0, go to IDLE with rr_ptr = (owner+1) mod NUM_REQ.
  - LOCKED, req_lock_in[owner]=0 while no transfer occurs:
    - Go to IDLE in the same cycle: arbitration uses the IDLE rules (eligible = all valid, rr_ptr = owner+1).
    - Next state is IDLE, or LOCKED again if the new winner locks.
- Owner valid low while lock is held: the FSM stays LOCKED and no flits move (owner stall). This is bounded only by the owner releasing its lock.

## Timing
- Reset values (reset=0 at a clock edge): up_valid_out=0, up_data_out=0, grant_id_out=0, locked_out=0, state IDLE, owner=0, burst_cnt=0, rr_ptr=0, counters=0.
- req_ready_out is 0 during reset, since up_valid_out is 0 but arbitration is forced off.
- Reset mid-operation: a flit held in the output register is discarded and no handshake completes.
- Latency: 1 cycle from the requester transfer edge to up_valid_out=1.
- Throughput: 1 flit/cycle while up_ready_in=1 (load and drain in the same cycle).
- While up_valid_out=1 && up_ready_in=0: up_data_out and grant_id_out hold stable and req_ready_out=0.
- Simultaneous drain and load: the new flit replaces the old one on the same edge, with no bubble.
- rr_ptr wraps from NUM_REQ-1 to 0.
- burst_cnt never exceeds MAX_BURST.

## Configuration
- ARB_STATS_EN defined:
  - grant_count_out[i*16 +: 16] counts completed transfers from requester i.
  - Counters saturate at 16'hFFFF and clear on reset.
- ARB_STATS_EN undefined: grant_count_out is driven constant 0 and no counter logic exists.

## Test plan
- Reset: hold reset=0 with all req_valid_in=1 → req_ready_out=0, up_valid_out=0, up_data_out=0. After release, the first grant goes to requester 0.
- Fairness: all 4 valid, no lock, up_ready_in=1 → grant_id_out sequence 0,1,2,3,0 on consecutive cycles, and up_data_out matches each source flit.
- Backpressure: up_ready_in=0 for 3 cycles with flit 16'h8C05 loaded → up_data_out stable at 16'h8C05, req_ready_out=0, no flit lost. On release, the next flit follows with no bubble.
- Burst lock: requester 2 holds lock with MAX_BURST=4 and all valid → 4 consecutive grants to 2, locked_out=1 for 3 cycles, then grant to 3.
- Early unlock and owner stall:
  - Owner 1 drops valid with lock=1 → no grants, others stalled.
  - Owner then drops lock → requester 2 is granted that same cycle.
- Stats (ARB_STATS_EN): 10 transfers from requester 3 → grant_count_out[63:48]=10. Without the macro the port reads 0.
